interrupt_sequencer: RTL and testbench

//  Upstream control stage of the 6502-style program counter.

---
 rtl/intc_pkg.sv | 46 ++++
 rtl/nmi_edge_detect.sv | 31 +++
 rtl/interrupt_sequencer.sv | 158 +++++++++++++++
 tb/tb_interrupt_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/intc_pkg.sv
// Shared types and constants for the 6502-style interrupt entry sequencer.
// Holds the sequence kinds, the default vector addresses and the cycle numbers that matter.
package intc_pkg;

    typedef enum logic [2:0] {
        INT_NONE  = 3'd0,
        INT_RESET = 3'd1,
        INT_NMI   = 3'd2,
        INT_IRQ   = 3'd3,
        INT_BRK   = 3'd4
    } int_kind_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEQ  = 1'b1
    } seq_state_e;

    localparam logic [15:0] NMI_VEC_DEF = 16'hFFFA;
    localparam logic [15:0] RST_VEC_DEF = 16'hFFFC;
    localparam logic [15:0] IRQ_VEC_DEF = 16'hFFFE;
    localparam int          SEQ_LEN_DEF = 7;

    localparam logic [2:0] PUSH_FIRST  = 3'd2;
    localparam logic [2:0] PUSH_LAST   = 3'd4;
    localparam logic [2:0] KIND_RESOLVE = 3'd4;
    localparam logic [2:0] VEC_LO      = 3'd5;
    localparam logic [2:0] VEC_HI      = 3'd6;

    // Low-byte vector address for a sequence kind; BRK shares the IRQ vector.
    function automatic logic [15:0] kind_vector(input int_kind_e kind,
                                                input logic [15:0] nmi_vec,
                                                input logic [15:0] rst_vec,
                                                input logic [15:0] irq_vec);
        logic [15:0] vec;
        vec = 16'h0000;
        case (kind)
            INT_RESET: vec = rst_vec;
            INT_NMI:   vec = nmi_vec;
            INT_IRQ,
            INT_BRK:   vec = irq_vec;
            default:   vec = 16'h0000;
        endcase
        return vec;
    endfunction

endpackage

// File: rtl/nmi_edge_detect.sv
// Falling-edge detector for the NMI line; the previous-level flop only advances on ce.
// Resets to "previously high" so a line held low through reset still counts as an edge.
module nmi_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic ce,
    input  logic nmi_n,
    output logic nmi_edge
);

    logic nmi_prev_q;
    logic nmi_prev_d;

    always_comb begin
        nmi_prev_d = nmi_prev_q;
        if (ce) begin
            nmi_prev_d = nmi_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nmi_prev_q <= 1'b1;
        end else begin
            nmi_prev_q <= nmi_prev_d;
        end
    end

    assign nmi_edge = ce & nmi_prev_q & ~nmi_n;

endmodule

// File: rtl/interrupt_sequencer.sv
// Polls RESET/NMI/IRQ at instruction boundaries and runs the 7-cycle interrupt/BRK entry,
// driving the stack-push enables, the vector fetch address and the final PC vector load.
module interrupt_sequencer
    import intc_pkg::*;
#(
    parameter logic [15:0] NMI_VEC = NMI_VEC_DEF,
    parameter logic [15:0] RST_VEC = RST_VEC_DEF,
    parameter logic [15:0] IRQ_VEC = IRQ_VEC_DEF,
    parameter int          SEQ_LEN = SEQ_LEN_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic        nmi_n,
    input  logic        irq_n,
    input  logic        i_flag,
    input  logic        instr_boundary,
    input  logic        brk_start,
    output logic        got_interrupt,
    output logic        seq_active,
    output logic [2:0]  seq_cycle,
    output logic        push_en,
    output logic        push_b_flag,
    output logic [15:0] vec_addr,
    output logic        set_i,
    output logic        load_pc_vec,
    output logic [2:0]  int_kind
);

    localparam logic [2:0] LAST_CYCLE = 3'(SEQ_LEN - 1);

    logic nmi_edge;

    nmi_edge_detect u_nmi_edge_detect (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce       (ce),
        .nmi_n    (nmi_n),
        .nmi_edge (nmi_edge)
    );

    seq_state_e  state_q, state_d;
    logic [2:0]  seq_cycle_q, seq_cycle_d;
    int_kind_e   kind_q, kind_d;
    logic        got_int_q, got_int_d;
    logic        brk_q, brk_d;
    logic        reset_pending_q, reset_pending_d;
    logic        nmi_pending_q, nmi_pending_d;

    logic        irq_req;
    logic        poll;
    logic        take;
    logic        hijack;
    logic [15:0] vec_base;

    always_comb begin
        state_d         = state_q;
        seq_cycle_d     = seq_cycle_q;
        kind_d          = kind_q;
        got_int_d       = got_int_q;
        brk_d           = brk_q;
        reset_pending_d = reset_pending_q;
        nmi_pending_d   = nmi_pending_q;

        irq_req = ~irq_n & ~i_flag;
        poll    = ce & instr_boundary & (state_q == ST_IDLE);
        take    = poll & (reset_pending_q | nmi_pending_q | irq_req);
        hijack  = ((kind_q == INT_IRQ) || (kind_q == INT_BRK)) && nmi_pending_q;

        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    state_d     = ST_SEQ;
                    seq_cycle_d = 3'd0;
                    got_int_d   = 1'b1;
                    brk_d       = 1'b0;
                    kind_d      = reset_pending_q ? INT_RESET :
                                  nmi_pending_q   ? INT_NMI   : INT_IRQ;
                end else if (ce && brk_start) begin
                    state_d     = ST_SEQ;
                    seq_cycle_d = 3'd0;
                    got_int_d   = 1'b0;
                    brk_d       = 1'b1;
                    kind_d      = INT_BRK;
                end
            end
            ST_SEQ: begin
                if (ce) begin
                    if (seq_cycle_q == LAST_CYCLE) begin
                        state_d     = ST_IDLE;
                        seq_cycle_d = 3'd0;
                        kind_d      = INT_NONE;
                        got_int_d   = 1'b0;
                        brk_d       = 1'b0;
                        if (kind_q == INT_RESET) begin
                            reset_pending_d = 1'b0;
                        end
                    end else begin
                        seq_cycle_d = seq_cycle_q + 3'd1;
                        // Late NMI steals an IRQ/BRK entry; the pushed B bit is already decided.
                        if (seq_cycle_q == KIND_RESOLVE) begin
                            if (hijack) begin
                                kind_d = INT_NMI;
                            end
                            if (hijack || (kind_q == INT_NMI)) begin
                                nmi_pending_d = 1'b0;
                            end
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A fresh edge always survives, even one landing on the resolve cycle.
        if (nmi_edge) begin
            nmi_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            seq_cycle_q     <= 3'd0;
            kind_q          <= INT_NONE;
            got_int_q       <= 1'b0;
            brk_q           <= 1'b0;
            reset_pending_q <= 1'b1;
            nmi_pending_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            seq_cycle_q     <= seq_cycle_d;
            kind_q          <= kind_d;
            got_int_q       <= got_int_d;
            brk_q           <= brk_d;
            reset_pending_q <= reset_pending_d;
            nmi_pending_q   <= nmi_pending_d;
        end
    end

    assign vec_base = kind_vector(kind_q, NMI_VEC, RST_VEC, IRQ_VEC);

    assign seq_active    = (state_q == ST_SEQ);
    assign got_interrupt = got_int_q;
    assign seq_cycle     = seq_cycle_q;
    assign int_kind      = kind_q;
    assign push_b_flag   = brk_q;
    assign push_en       = seq_active && (seq_cycle_q >= PUSH_FIRST) &&
                           (seq_cycle_q <= PUSH_LAST) && (kind_q != INT_RESET);
    assign set_i         = seq_active && (seq_cycle_q == VEC_LO);
    assign load_pc_vec   = seq_active && (seq_cycle_q == VEC_HI);
    assign vec_addr      = !seq_active              ? 16'h0000 :
                           (seq_cycle_q == VEC_LO)  ? vec_base :
                           (seq_cycle_q == VEC_HI)  ? vec_base + 16'd1 : 16'h0000;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench: vector table plus hand-written corner sequences, checked through an
// expected-result queue that is filled when a cycle is driven and drained after its edge.
module tb_interrupt_sequencer;
    import intc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce = 1'b1;
    logic        nmi_n = 1'b1;
    logic        irq_n = 1'b1;
    logic        i_flag = 1'b1;
    logic        instr_boundary = 1'b0;
    logic        brk_start = 1'b0;
    logic        got_interrupt, seq_active, push_en, push_b_flag, set_i, load_pc_vec;
    logic [2:0]  seq_cycle, int_kind;
    logic [15:0] vec_addr;

    interrupt_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ce             (ce),
        .nmi_n          (nmi_n),
        .irq_n          (irq_n),
        .i_flag         (i_flag),
        .instr_boundary (instr_boundary),
        .brk_start      (brk_start),
        .got_interrupt  (got_interrupt),
        .seq_active     (seq_active),
        .seq_cycle      (seq_cycle),
        .push_en        (push_en),
        .push_b_flag    (push_b_flag),
        .vec_addr       (vec_addr),
        .set_i          (set_i),
        .load_pc_vec    (load_pc_vec),
        .int_kind       (int_kind)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        got;
        logic        act;
        logic [2:0]  cyc;
        logic        push;
        logic        bflag;
        logic [15:0] vec;
        logic        seti;
        logic        ld;
        logic [2:0]  kind;
    } obs_t;

    typedef struct {
        logic  ce, nmi_n, irq_n, i_flag, bnd, brk;
        obs_t  exp;
        string name;
    } vec_t;

    vec_t  tbl[$];
    obs_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    int    tx = 0;

    localparam obs_t IDLE = '0;

    // Expected outputs for cycle c of a sequence of the given kind, straight from the port table.
    function automatic obs_t seq_obs(int_kind_e k, int c, logic got, logic b);
        obs_t o;
        logic [15:0] v;
        v = (k == INT_RESET) ? 16'hFFFC : (k == INT_NMI) ? 16'hFFFA : 16'hFFFE;
        o.got   = got;
        o.act   = 1'b1;
        o.cyc   = 3'(c);
        o.push  = (c >= 2) && (c <= 4) && (k != INT_RESET);
        o.bflag = b;
        o.vec   = (c == 5) ? v : (c == 6) ? v + 16'd1 : 16'h0000;
        o.seti  = (c == 5);
        o.ld    = (c == 6);
        o.kind  = k;
        return o;
    endfunction

    function automatic obs_t cur_obs();
        obs_t o;
        o.got   = got_interrupt;
        o.act   = seq_active;
        o.cyc   = seq_cycle;
        o.push  = push_en;
        o.bflag = push_b_flag;
        o.vec   = vec_addr;
        o.seti  = set_i;
        o.ld    = load_pc_vec;
        o.kind  = int_kind;
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("got=%b act=%b cyc=%0d push=%b b=%b vec=%h set_i=%b ld=%b kind=%0d",
                         o.got, o.act, o.cyc, o.push, o.bflag, o.vec, o.seti, o.ld, o.kind);
    endfunction

    task automatic compare(obs_t act, obs_t exp, string nm);
        checks++;
        tx++;
        if (act !== exp) begin
            errors++;
            $display("FAIL [%0d] %s: actual {%s} required {%s}", tx, nm, fmt(act), fmt(exp));
        end else begin
            $display("ok   [%0d] %s: {%s}", tx, nm, fmt(act));
        end
    endtask

    task automatic check_pop();
        obs_t  e;
        string nm;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: actual empty queue, required one pending entry");
        end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            compare(cur_obs(), e, nm);
        end
    endtask

    task automatic step(logic c_ce, logic c_nmi, logic c_irq, logic c_if, logic c_bnd,
                        logic c_brk, obs_t e, string nm);
        ce             = c_ce;
        nmi_n          = c_nmi;
        irq_n          = c_irq;
        i_flag         = c_if;
        instr_boundary = c_bnd;
        brk_start      = c_brk;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        check_pop();
    endtask

    task automatic add(logic c_ce, logic c_nmi, logic c_irq, logic c_if, logic c_bnd,
                       logic c_brk, obs_t e, string nm);
        vec_t v;
        v.ce = c_ce; v.nmi_n = c_nmi; v.irq_n = c_irq; v.i_flag = c_if;
        v.bnd = c_bnd; v.brk = c_brk; v.exp = e; v.name = nm;
        tbl.push_back(v);
    endtask

    initial begin
        // RESET entry after release; reset_pending is gone afterwards.
        add(1, 1, 1, 1, 0, 0, IDLE, "rst_wait_boundary");
        add(1, 1, 1, 1, 1, 0, seq_obs(INT_RESET, 0, 1'b1, 1'b0), "rst_take");
        for (int c = 1; c <= 6; c++)
            add(1, 1, 1, 1, 0, 0, seq_obs(INT_RESET, c, 1'b1, 1'b0), $sformatf("rst_cyc%0d", c));
        add(1, 1, 1, 1, 0, 0, IDLE, "rst_done");
        add(1, 1, 1, 1, 1, 0, IDLE, "rst_pending_cleared");
        // IRQ taken with a coincident BRK (dropped); IRQ line changes mid-sequence ignored.
        add(1, 1, 0, 0, 1, 1, seq_obs(INT_IRQ, 0, 1'b1, 1'b0), "irq_take_brk_dropped");
        for (int c = 1; c <= 6; c++)
            add(1, 1, 1, 0, 0, 0, seq_obs(INT_IRQ, c, 1'b1, 1'b0), $sformatf("irq_cyc%0d", c));
        add(1, 1, 1, 0, 0, 0, IDLE, "irq_done");
        // Masked IRQ and a poll with ce low never start anything.
        add(1, 1, 0, 1, 1, 0, IDLE, "irq_masked_a");
        add(1, 1, 0, 1, 1, 0, IDLE, "irq_masked_b");
        add(0, 1, 0, 0, 1, 0, IDLE, "poll_ce_low");
        add(1, 1, 1, 1, 0, 0, IDLE, "quiet");

        #2;
        compare(cur_obs(), IDLE, "reset_async");
        @(posedge clk);
        #1;
        compare(cur_obs(), IDLE, "reset_held");
        rst_n = 1'b1;

        foreach (tbl[i])
            step(tbl[i].ce, tbl[i].nmi_n, tbl[i].irq_n, tbl[i].i_flag, tbl[i].bnd, tbl[i].brk,
                 tbl[i].exp, tbl[i].name);

        // BRK hijacked by an NMI edge sampled in cycle 3.
        step(1, 1, 1, 1, 0, 1, seq_obs(INT_BRK, 0, 1'b0, 1'b1), "brk_start");
        for (int c = 1; c <= 3; c++)
            step(1, 1, 1, 1, 0, 0, seq_obs(INT_BRK, c, 1'b0, 1'b1), $sformatf("brk_cyc%0d", c));
        step(1, 0, 1, 1, 0, 0, seq_obs(INT_BRK, 4, 1'b0, 1'b1), "brk_cyc4_pre_hijack");
        step(1, 0, 1, 1, 0, 0, seq_obs(INT_NMI, 5, 1'b0, 1'b1), "hijack_cyc5");
        step(1, 0, 1, 1, 0, 0, seq_obs(INT_NMI, 6, 1'b0, 1'b1), "hijack_cyc6");
        step(1, 0, 1, 1, 0, 0, IDLE, "hijack_done");
        step(1, 0, 1, 1, 1, 0, IDLE, "nmi_pending_cleared");
        step(1, 1, 1, 1, 0, 0, IDLE, "nmi_release");

        // NMI edge in cycle 6 of an IRQ entry waits for the next boundary.
        step(1, 1, 0, 0, 1, 0, seq_obs(INT_IRQ, 0, 1'b1, 1'b0), "irq2_take");
        for (int c = 1; c <= 6; c++)
            step(1, 1, 1, 1, 0, 0, seq_obs(INT_IRQ, c, 1'b1, 1'b0), $sformatf("irq2_cyc%0d", c));
        step(1, 0, 1, 1, 0, 0, IDLE, "irq2_done_nmi_edge");
        step(1, 0, 1, 1, 0, 0, IDLE, "nmi_not_immediate_a");
        step(1, 0, 1, 1, 0, 0, IDLE, "nmi_not_immediate_b");
        step(1, 0, 0, 0, 1, 0, seq_obs(INT_NMI, 0, 1'b1, 1'b0), "nmi_over_irq");
        step(1, 1, 1, 1, 0, 0, seq_obs(INT_NMI, 1, 1'b1, 1'b0), "nmi_cyc1");
        step(1, 1, 1, 1, 0, 0, seq_obs(INT_NMI, 2, 1'b1, 1'b0), "nmi_cyc2");
        step(0, 1, 1, 1, 1, 1, seq_obs(INT_NMI, 2, 1'b1, 1'b0), "ce_hold_a");
        step(0, 1, 1, 1, 0, 0, seq_obs(INT_NMI, 2, 1'b1, 1'b0), "ce_hold_b");
        step(1, 1, 1, 1, 0, 0, seq_obs(INT_NMI, 3, 1'b1, 1'b0), "nmi_cyc3");

        // Asynchronous reset in cycle 3 aborts; next entry is RESET even with an IRQ up.
        #2;
        rst_n = 1'b0;
        #1;
        compare(cur_obs(), IDLE, "reset_mid_seq");
        @(posedge clk);
        #1;
        compare(cur_obs(), IDLE, "reset_mid_seq_held");
        rst_n = 1'b1;
        step(1, 1, 1, 1, 0, 0, IDLE, "after_reset_idle");
        step(1, 1, 0, 0, 1, 0, seq_obs(INT_RESET, 0, 1'b1, 1'b0), "reset_over_irq");
        for (int c = 1; c <= 6; c++)
            step(1, 1, 1, 1, 0, 0, seq_obs(INT_RESET, c, 1'b1, 1'b0), $sformatf("rst2_cyc%0d", c));
        step(1, 1, 1, 1, 0, 0, IDLE, "rst2_done");
        step(1, 1, 1, 1, 1, 0, IDLE, "rst2_pending_cleared");

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: actual %0d left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
